// File: rtl/moore_1010_detector_if.sv
// moore_1010_detector_if
//   Serial data path between a bit source and the 1010 detector.
//   Signals:
//     in  - serial data bit, one per clock (source -> detector)
//     out - match flag, high for one cycle per detection (detector -> sink)
//   Modports:
//     master - bit source / flag consumer (drives in, reads out)
//     slave  - detector (reads in, drives out)
interface moore_1010_detector_if;
  logic in;
  logic out;

  modport master (output in, input out);
  modport slave  (input in, output out);
endinterface

// File: rtl/moore_1010_detector.sv
// moore_1010_detector
//   Moore FSM that flags the serial pattern 1-0-1-0. The flag is decoded
//   from the registered state only, so it never follows 'in' combinationally.
//   Ports:
//     clk - sole clock, rising edge
//     rst - synchronous active-high reset
//     bus - moore_1010_detector_if.slave (in: serial bit, out: match flag)
//   Build option:
//     MOORE_1010_OVERLAP_EN - when defined, a hit's trailing "10" is reused
//     as the start of the next pattern (101010 gives two hits); when
//     undefined, detection restarts after each hit (101010 gives one hit).
//
//   state | meaning
//   ------+-------------------------------
//   S0    | idle / no progress
//   S1    | seen "1"
//   S2    | seen "10"
//   S3    | seen "101"
//   S4    | seen "1010", out = 1
module moore_1010_detector (
  input  logic                       clk,
  input  logic                       rst,
  moore_1010_detector_if.slave       bus
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t ps;
  state_t ns;

  always_ff @(posedge clk) begin
    if (rst) begin
      ps <= S0;
    end else begin
      ps <= ns;
    end
  end

  // Unused codes fall through to the S0 default.
  always_comb begin
    ns = S0;
    case (ps)
      S0: ns = bus.in ? S1 : S0;
      S1: ns = bus.in ? S1 : S2;
      S2: ns = bus.in ? S3 : S0;
      S3: ns = bus.in ? S1 : S4;
`ifdef MOORE_1010_OVERLAP_EN
      // Trailing "10" of the hit plus this "1" already forms "101".
      S4: ns = bus.in ? S3 : S0;
`else
      S4: ns = bus.in ? S1 : S0;
`endif
      default: ns = S0;
    endcase
  end

  assign bus.out = (ps == S4);

endmodule

// File: tb/tb_moore_1010_detector.sv
module tb_moore_1010_detector;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  moore_1010_detector_if bus ();

  moore_1010_detector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bits seen since the last restart point. The expected
  // state is the length of the longest suffix of that history which is a
  // prefix of 1010; reaching 4 is a hit. Without overlap the history is
  // cleared after each hit so no bits of the hit are reused.
  bit hist[$];
  bit pat[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  task automatic model_reset();
    hist.delete();
  endtask

  task automatic model_step(input bit b, output int exp_ps, output logic exp_out);
    bit ok;
    hist.push_back(b);
    while (hist.size() > 4) void'(hist.pop_front());
    exp_ps = 0;
    for (int k = 4; k >= 1; k--) begin
      if (exp_ps == 0 && hist.size() >= k) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (hist[hist.size() - k + j] != pat[j]) ok = 1'b0;
        if (ok) exp_ps = k;
      end
    end
    exp_out = (exp_ps == 4);
`ifndef MOORE_1010_OVERLAP_EN
    if (exp_ps == 4) hist.delete();
`endif
  endtask

  // Drive one bit away from the active edge, sample 1 time unit after it.
  task automatic drive_bit(input logic b);
    @(negedge clk);
    rst    = 1'b0;
    bus.in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reset(input logic b);
    @(negedge clk);
    rst    = 1'b1;
    bus.in = b;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    drive_reset(1'bx);
    total++;
    if (dut.ps !== 3'd0) begin
      bad++;
      $display("FAIL reset_ps got=%0d want=0", dut.ps);
    end
    total++;
    if (bus.out !== 1'b0) begin
      bad++;
      $display("FAIL reset_out got=%b want=0", bus.out);
    end
  endtask

  task automatic test_reference_stream();
    bit stream[16] = '{0,1,0,0,0,1,0,1,0,1,1,0,1,0,0,1};
`ifdef MOORE_1010_OVERLAP_EN
    int tbl[16] = '{0,1,2,0,0,1,2,3,4,3,1,2,3,4,0,1};
`else
    int tbl[16] = '{0,1,2,0,0,1,2,3,4,1,1,2,3,4,0,1};
`endif
    int   mps;
    logic mout;
    drive_reset(1'b0);
    for (int i = 0; i < 16; i++) begin
      drive_bit(stream[i]);
      model_step(stream[i], mps, mout);
      total++;
      if (dut.ps !== 3'(tbl[i]) || dut.ps !== 3'(mps)) begin
        bad++;
        $display("FAIL ref_ps bit=%0d got=%0d want=%0d model=%0d", i + 1, dut.ps, tbl[i], mps);
      end
      total++;
      if (bus.out !== ((i == 8 || i == 13) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL ref_out bit=%0d got=%b want=%b", i + 1, bus.out, (i == 8 || i == 13));
      end
    end
  endtask

  task automatic test_overlap();
    bit stream[6] = '{1,0,1,0,1,0};
    logic want;
    drive_reset(1'b0);
    for (int i = 0; i < 6; i++) begin
      drive_bit(stream[i]);
`ifdef MOORE_1010_OVERLAP_EN
      want = (i == 3 || i == 5);
`else
      want = (i == 3);
`endif
      total++;
      if (bus.out !== want) begin
        bad++;
        $display("FAIL overlap_out bit=%0d got=%b want=%b", i + 1, bus.out, want);
      end
    end
  endtask

  task automatic test_non_patterns();
    bit stream[14] = '{1,1,1,1,0,0,0,0,1,0,0,1,0,0};
    int   mps;
    logic mout;
    drive_reset(1'b0);
    for (int i = 0; i < 14; i++) begin
      drive_bit(stream[i]);
      model_step(stream[i], mps, mout);
      total++;
      if (bus.out !== 1'b0 || dut.ps === 3'd4 || dut.ps !== 3'(mps)) begin
        bad++;
        $display("FAIL nonpat bit=%0d out=%b ps=%0d want out=0 ps=%0d", i + 1, bus.out, dut.ps, mps);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit pre[3] = '{1,0,1};
    drive_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_bit(pre[i]);
      total++;
      if (bus.out !== 1'b0 || dut.ps !== 3'(i + 1)) begin
        bad++;
        $display("FAIL midrst_pre bit=%0d out=%b ps=%0d want out=0 ps=%0d", i + 1, bus.out, dut.ps, i + 1);
      end
    end
    drive_reset(1'b0);
    total++;
    if (dut.ps !== 3'd0 || bus.out !== 1'b0) begin
      bad++;
      $display("FAIL midrst_edge ps=%0d out=%b want ps=0 out=0", dut.ps, bus.out);
    end
    drive_bit(1'b0);
    total++;
    if (dut.ps !== 3'd0 || bus.out !== 1'b0) begin
      bad++;
      $display("FAIL midrst_after ps=%0d out=%b want ps=0 out=0", dut.ps, bus.out);
    end
  endtask

  task automatic test_reset_in_s4();
    bit pre[4] = '{1,0,1,0};
    for (int r = 0; r < 2; r++) begin
      drive_reset(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(pre[i]);
      total++;
      if (bus.out !== 1'b1) begin
        bad++;
        $display("FAIL s4_hit got=%b want=1", bus.out);
      end
      drive_reset(r[0]);
      total++;
      if (dut.ps !== 3'd0 || bus.out !== 1'b0) begin
        bad++;
        $display("FAIL s4_reset in=%0d ps=%0d out=%b want ps=0 out=0", r, dut.ps, bus.out);
      end
    end
  endtask

  task automatic test_random();
    int   mps;
    logic mout;
    logic prev_out;
    bit   b;
    drive_reset(1'b0);
    prev_out = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 3) begin
        drive_reset(1'($urandom));
        mps  = 0;
        mout = 1'b0;
      end else begin
        // Bias toward alternation so hits and overlaps occur often.
        b = ($urandom_range(99) < 70) ? ~b : 1'($urandom);
        drive_bit(b);
        model_step(b, mps, mout);
      end
      total++;
      if (dut.ps !== 3'(mps) || bus.out !== mout) begin
        bad++;
        $display("FAIL random step=%0d ps=%0d out=%b want ps=%0d out=%b", i, dut.ps, bus.out, mps, mout);
      end
      total++;
      if (prev_out === 1'b1 && bus.out === 1'b1) begin
        bad++;
        $display("FAIL random_back_to_back step=%0d out=1 twice want single pulse", i);
      end
      prev_out = bus.out;
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b0;
    bus.in = 1'b0;
    test_reset();
    test_reference_stream();
    test_overlap();
    test_non_patterns();
    test_mid_reset();
    test_reset_in_s4();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
